// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : sequencer state encoding (IDLE / RUN / DONE)
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operation request / result bundle for serial_adder_ctrl.
//   master : requester side (drives start, sub, a, b, c_in; sees results)
//   slave  : sequencer side (consumes request; drives busy, done, sum, c_out, ovf)
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/bit_adder_cell.sv
// One-bit combinational full adder; the only arithmetic in the sequencer.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module bit_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer. Walks one full-adder cell LSB-first
// over WIDTH cycles and publishes sum, carry-out and signed overflow with a
// one-cycle done strobe.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : request/result bundle (slave side)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; result registers hold last result
// RUN     | one operand bit processed per cycle, cnt = bit index
// DONE    | done strobe; start here chains straight into RUN
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_sr_q, acc_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load;
    logic             cell_s, cell_co;

    bit_adder_cell u_cell (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        acc_sr_d = acc_sr_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: load = bus.start;
            ST_RUN: begin
                acc_sr_d = {cell_s, acc_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = cell_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // carry_q is the carry into the MSB during this last step
                    sum_d   = {cell_s, acc_sr_q[WIDTH-1:1]};
                    c_out_d = cell_co;
                    ovf_d   = carry_q ^ cell_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                load    = bus.start;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Subtract is a + ~b + 1: invert B and force the initial carry.
        if (load) begin
            a_sr_d  = bus.a;
            b_sr_d  = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub ? 1'b1 : bus.c_in;
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            acc_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            acc_sr_q <= acc_sr_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } res_t;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        res_t         e;
    } vec_t;

    res_t exp_q[$];
    res_t mon_r;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic using plain integer add and sign rules.
    function automatic res_t model(input logic s, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci);
        res_t         r;
        logic [W:0]   full;
        int           sa, sb, sr;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        if (s) begin
            full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            sr   = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            sr   = sa + sb + int'(ci);
        end
        r.sum = full[W-1:0];
        r.co  = full[W];
        r.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return r;
    endfunction

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("done_busy_excl", int'(bus.busy), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with sum=0x%0h expected no done", bus.sum);
            end else begin
                mon_r = exp_q.pop_front();
                check("sum",   int'(bus.sum),   int'(mon_r.sum));
                check("c_out", int'(bus.c_out), int'(mon_r.co));
                check("ovf",   int'(bus.ovf),   int'(mon_r.ovf));
            end
        end
    end

    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = ci;
    endtask

    // Issue one operation and return start-to-done latency and busy cycles.
    // poke_at > 0 re-asserts start with other operands in that RUN cycle.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input res_t e, input int poke_at,
                          output int lat, output int busy_n);
        @(posedge clk); #1;
        drive(s, a, b, ci);
        exp_q.push_back(e);
        lat    = 0;
        busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (n == poke_at) drive(~s, ~a, a, ~ci);
        end
    endtask

    vec_t vecs[8];
    int   lat, busy_n;
    res_t r1, r2;

    initial begin
        vecs[0] = '{1'b0, 8'h5A, 8'h33, 1'b0, '{8'h8D, 1'b0, 1'b1}};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, '{8'h01, 1'b0, 1'b0}};
        vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, '{8'hF0, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, '{8'h7F, 1'b1, 1'b1}};
        vecs[5] = '{1'b1, 8'h05, 8'h03, 1'b1, '{8'h02, 1'b1, 1'b0}};
        vecs[6] = '{1'b0, 8'h7F, 8'h7F, 1'b1, '{8'hFF, 1'b0, 1'b1}};
        vecs[7] = '{1'b1, 8'h7F, 8'h80, 1'b0, '{8'hFF, 1'b0, 1'b1}};

        // Reset held together with start: reset must win.
        drive(1'b0, 8'h5A, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_done",  int'(bus.done),  0);
        check("rst_sum",   int'(bus.sum),   0);
        check("rst_c_out", int'(bus.c_out), 0);
        check("rst_ovf",   int'(bus.ovf),   0);
        bus.start = 1'b0;
        rst       = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].e, 0, lat, busy_n);
            check("latency", lat, 9);
            check("busy_cycles", busy_n, 8);
        end

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs, rc;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(rs, ra, rb, rc, model(rs, ra, rb, rc), 0, lat, busy_n);
            check("rand_latency", lat, 9);
        end

        // Back-to-back: start held in the DONE cycle.
        r1 = model(1'b0, 8'h10, 8'h20, 1'b0);
        run_op(1'b0, 8'h10, 8'h20, 1'b0, r1, 0, lat, busy_n);
        check("b2b_first_latency", lat, 9);
        drive(1'b0, 8'h01, 8'h02, 1'b0);
        r2 = '{8'h03, 1'b0, 1'b0};
        exp_q.push_back(r2);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
            check("b2b_hold_sum", int'(bus.sum), int'(r1.sum));
        end
        check("b2b_second_latency", lat, 9);

        // start pulsed mid-RUN is ignored.
        r1 = model(1'b0, 8'h12, 8'h34, 1'b0);
        run_op(1'b0, 8'h12, 8'h34, 1'b0, r1, 3, lat, busy_n);
        check("poke_latency", lat, 9);
        check("poke_busy", busy_n, 8);
        @(posedge clk); #1;
        check("poke_idle_after", int'(bus.busy), 0);

        // Leave non-zero result registers, then reset mid-operation.
        run_op(1'b1, 8'h80, 8'h01, 1'b0, '{8'h7F, 1'b1, 1'b1}, 0, lat, busy_n);
        check("pre_rst_latency", lat, 9);
        @(posedge clk); #1;
        drive(1'b0, 8'h5A, 8'h33, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check("mid_busy_before_rst", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy",  int'(bus.busy),  0);
        check("mid_rst_done",  int'(bus.done),  0);
        check("mid_rst_sum",   int'(bus.sum),   0);
        check("mid_rst_c_out", int'(bus.c_out), 0);
        check("mid_rst_ovf",   int'(bus.ovf),   0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_idle", int'(bus.busy), 0);
        run_op(1'b0, 8'h01, 8'h01, 1'b1, '{8'h03, 1'b0, 1'b0}, 0, lat, busy_n);
        check("post_rst_latency", lat, 9);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
